seg_serial_rx: RTL and testbench

Serial receiver and decoder at the far end of the 32-bit segment link driven by the display serializer.
- Deserializes the LSB-first bit stream (data_in, with a last-bit strobe sync_in) into a 32-bit segment word.
- Decodes each 8-bit digit field back to BCD.
- Flags framing, decode and link-loss errors.
- Used on the display board side and as a loopback checker in the calculator top level.

---
 rtl/seg_serial_rx.sv | 143 ++++++++++++++
 tb/tb_seg_serial_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_serial_rx.sv
// ============================================================================
//  Module   : seg_serial_rx
//  Purpose  : Serial receiver for the 32-bit segment link.
//             Builds each frame from the serial bits, decodes the digits back
//             to BCD, and flags framing, decode and link-loss errors.
//             When SEG_RX_ACTIVE_LOW_EN is defined, the segment bits are
//             decoded as active-low (common-anode boards).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_serial_rx #(
  parameter int NUM_DIGITS   = 4,
  parameter int LINK_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      data_in,
  input  logic                      sync_in,
  output logic [8*NUM_DIGITS-1:0]   seg_word,
  output logic                      word_valid,
  output logic [4*NUM_DIGITS-1:0]   bcd_out,
  output logic [NUM_DIGITS-1:0]     dp_out,
  output logic                      bcd_valid,
  output logic                      decode_err,
  output logic                      frame_err,
  output logic                      link_lost
);

  localparam int                  c_FRAME_BITS = 8 * NUM_DIGITS;
  localparam int                  c_CNT_W      = $clog2(c_FRAME_BITS + 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_MAX    = c_CNT_W'(c_FRAME_BITS);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST   = c_CNT_W'(c_FRAME_BITS - 1);
  localparam logic [15:0]         c_TIMEOUT    = 16'(LINK_TIMEOUT);

  logic [c_FRAME_BITS-1:0] r_shreg;
  logic [c_CNT_W-1:0]      r_bit_cnt;
  logic [15:0]             r_timeout;
  logic [c_FRAME_BITS-1:0] w_next_shreg;

  logic [4*NUM_DIGITS-1:0] w_bcd;
  logic [NUM_DIGITS-1:0]   w_dp;
  logic [NUM_DIGITS-1:0]   w_bad;

  assign w_next_shreg = {data_in, r_shreg[c_FRAME_BITS-1:1]};

  // Receive path: shift, frame capture, short-frame resync and link watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_timeout  <= '0;
      seg_word   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      link_lost  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (enable) begin
        r_shreg <= w_next_shreg;
        if (sync_in) begin
          r_bit_cnt <= '0;
          if (r_bit_cnt >= c_CNT_LAST) begin
            seg_word   <= w_next_shreg;
            word_valid <= 1'b1;
            r_timeout  <= '0;
            link_lost  <= 1'b0;
          end else begin
            frame_err  <= 1'b1;
          end
        end else begin
          if (r_bit_cnt != c_CNT_MAX) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          if (r_timeout != c_TIMEOUT) begin
            r_timeout <= r_timeout + 16'd1;
          end
          if (r_timeout >= c_TIMEOUT - 16'd1) begin
            link_lost <= 1'b1;
          end
        end
      end
    end
  end

  // Per-digit seven-segment to BCD lookup
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [7:0] w_byte;
    logic [3:0] w_digit;
    logic       w_illegal;

`ifdef SEG_RX_ACTIVE_LOW_EN
    assign w_byte = ~seg_word[8*k +: 8];
`else
    assign w_byte = seg_word[8*k +: 8];
`endif

    always_comb begin
      w_digit   = 4'hE;
      w_illegal = 1'b0;
      case (w_byte[6:0])
        7'h3F:   w_digit = 4'h0;
        7'h06:   w_digit = 4'h1;
        7'h5B:   w_digit = 4'h2;
        7'h4F:   w_digit = 4'h3;
        7'h66:   w_digit = 4'h4;
        7'h6D:   w_digit = 4'h5;
        7'h7D:   w_digit = 4'h6;
        7'h07:   w_digit = 4'h7;
        7'h7F:   w_digit = 4'h8;
        7'h6F:   w_digit = 4'h9;
        7'h00:   w_digit = 4'hF;
        default: w_illegal = 1'b1;
      endcase
    end

    assign w_bcd[4*k +: 4] = w_digit;
    assign w_dp[k]         = w_byte[7];
    assign w_bad[k]        = w_illegal;
  end

  // Decode stage runs off the word_valid pulse, so it completes even while paused
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_out    <= '0;
      dp_out     <= '0;
      bcd_valid  <= 1'b0;
      decode_err <= 1'b0;
    end else begin
      bcd_valid <= word_valid;
      if (word_valid) begin
        bcd_out    <= w_bcd;
        dp_out     <= w_dp;
        decode_err <= |w_bad;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_serial_rx.sv
// ============================================================================
//  Module   : tb_seg_serial_rx
//  Purpose  : Randomized self-checking bench for seg_serial_rx against a
//             bit-history reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_serial_rx;

  localparam int c_LINK_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        data_in;
  logic        sync_in;
  logic [31:0] seg_word;
  logic        word_valid;
  logic [15:0] bcd_out;
  logic [3:0]  dp_out;
  logic        bcd_valid;
  logic        decode_err;
  logic        frame_err;
  logic        link_lost;

  int n_total = 0;
  int n_bad   = 0;

  seg_serial_rx #(.NUM_DIGITS(4), .LINK_TIMEOUT(c_LINK_TIMEOUT)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .data_in    (data_in),
    .sync_in    (sync_in),
    .seg_word   (seg_word),
    .word_valid (word_valid),
    .bcd_out    (bcd_out),
    .dp_out     (dp_out),
    .bcd_valid  (bcd_valid),
    .decode_err (decode_err),
    .frame_err  (frame_err),
    .link_lost  (link_lost)
  );

  always #5 clk = ~clk;

  // Reference model state: raw bit history rather than a shift register
  bit          m_hist[$];
  int          m_since;
  int          m_idle;
  logic [31:0] m_word;
  logic        m_wv, m_fe, m_lost, m_bv, m_derr;
  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  logic [6:0]  m_codes[10];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_decode(input logic [31:0] w, output logic [15:0] b,
                              output logic [3:0] dp, output logic err);
    logic [7:0] by;
    int         val;
    err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      by  = w[8*k +: 8];
      val = -1;
      if (by[6:0] == 7'h00) val = 15;
      for (int j = 0; j < 10; j++) if (m_codes[j] == by[6:0]) val = j;
      if (val < 0) begin
        val = 14;
        err = 1'b1;
      end
      b[4*k +: 4] = 4'(val);
      dp[k]       = by[7];
    end
  endtask

  function automatic logic [31:0] hist_word();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w[i] = m_hist[m_hist.size() - 32 + i];
    return w;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < 32; i++) m_hist.push_back(1'b0);
    m_since = 0; m_idle = 0; m_word = '0;
    m_wv = 0; m_fe = 0; m_lost = 0; m_bv = 0; m_derr = 0; m_bcd = '0; m_dp = '0;
  endtask

  task automatic cyc(input logic r, input logic e, input logic d, input logic s);
    logic prev_wv;
    rst = r; enable = e; data_in = d; sync_in = s;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      prev_wv = m_wv;
      m_bv    = prev_wv;
      if (prev_wv) model_decode(m_word, m_bcd, m_dp, m_derr);
      m_wv = 0;
      m_fe = 0;
      if (e) begin
        m_hist.push_back(d);
        void'(m_hist.pop_front());
        if (s) begin
          if (m_since >= 31) begin
            m_word = hist_word();
            m_wv   = 1;
            m_idle = 0;
            m_lost = 0;
          end else begin
            m_fe = 1;
          end
          m_since = 0;
        end else begin
          m_since++;
          m_idle++;
          if (m_idle >= c_LINK_TIMEOUT) m_lost = 1;
        end
      end
    end
    check_val("seg_word",   seg_word,   m_word);
    check_val("word_valid", word_valid, m_wv);
    check_val("frame_err",  frame_err,  m_fe);
    check_val("link_lost",  link_lost,  m_lost);
    check_val("bcd_valid",  bcd_valid,  m_bv);
    check_val("bcd_out",    bcd_out,    m_bcd);
    check_val("dp_out",     dp_out,     m_dp);
    check_val("decode_err", decode_err, m_derr);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
  endtask

  task automatic maybe_pause(input int pct);
    if ($urandom_range(99) < pct)
      repeat ($urandom_range(5, 1)) cyc(0, 0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input bit sync_last, input int pct);
    for (int i = 0; i < n; i++) begin
      maybe_pause(pct);
      cyc(0, 1, w[i], sync_last && (i == n - 1));
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input int gap, input int pct);
    for (int i = 0; i < gap; i++) cyc(0, 1, 1'($urandom), 0);
    send_bits(w, 32, 1, pct);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
  endtask

  function automatic logic [31:0] rand_frame();
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(99) < 80)
        w[8*k +: 8] = {1'($urandom), m_codes[$urandom_range(9)]};
      else if ($urandom_range(1) == 0)
        w[8*k +: 8] = {1'($urandom), 7'h00};
      else
        w[8*k +: 8] = 8'($urandom);
    end
    return w;
  endfunction

  initial begin
    m_codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    model_reset();
    rst = 1; enable = 0; data_in = 0; sync_in = 0;

    do_reset();

    // Directed frames from the link's typical traffic
    send_frame(32'h065B4F66, 0, 0);
    send_frame(32'h3F3F3F3F, 2, 0);
    send_frame(32'h6F7F0706, 2, 0);

    // Short frame straight after reset, then recovery
    do_reset();
    send_bits(32'h000ABCDE, 20, 1, 0);
    cyc(0, 1, 0, 0);
    send_frame(32'h00000006, 0, 0);

    // Illegal and dp patterns, then a clean frame clears decode_err
    send_frame(32'h80770006, 2, 0);
    send_frame(32'h80FF0006, 2, 0);
    send_frame(32'h065B4F66, 2, 0);

    // Link timeout and recovery
    do_reset();
    repeat (c_LINK_TIMEOUT + 6) cyc(0, 1, 1'($urandom), 0);
    send_frame(32'h4F4F4F4F, 0, 0);

    // Pause mid-frame, then reset mid-frame and a short sync
    send_bits(32'h5B5B5B5B, 10, 0, 0);
    repeat (5) cyc(0, 0, 1'($urandom), 1'($urandom));
    send_bits(32'h0, 5, 0, 0);
    do_reset();
    send_bits(32'h12345678, 8, 1, 0);
    send_frame(32'h7D6D664F, 0, 0);

    // Randomized traffic with pauses, short frames and occasional resets
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(19))
        0:       do_reset();
        1, 2:    send_bits(32'($urandom), $urandom_range(30, 1), 1, 10);
        default: send_frame(rand_frame(), $urandom_range(3), 10);
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
